// File: rtl/taxi_eth_phy_10g_rx_block_lock.sv
// 10GBASE-R receive block-lock FSM: hunts for sync-header alignment by requesting
// gearbox bitslips, declares lock after 64 good headers, drops it on 16 bad in a window.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// UNLOCKED  | hunting: counting consecutive valid headers toward 64
// LOCKED    | aligned: counting bad headers per 64-header window
// SLIP      | bitslip request held high to the gearbox
// SLIP_WAIT | bitslip low, headers ignored while the gearbox settles
module taxi_eth_phy_10g_rx_block_lock #(
    parameter int HDR_W               = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [HDR_W-1:0] serdes_rx_hdr,
    input  logic             serdes_rx_hdr_valid,
    input  logic             serdes_rx_reset_req,
    output logic             serdes_rx_bitslip,
    output logic             rx_block_lock,
    output logic             rx_lock_loss,
    output logic [7:0]       rx_slip_count
);

    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "taxi_eth_phy_10g_rx_block_lock: HDR_W must be 2");
    end
    if (BITSLIP_HIGH_CYCLES < 1) begin : g_bad_high
        $fatal(1, "taxi_eth_phy_10g_rx_block_lock: BITSLIP_HIGH_CYCLES must be >= 1");
    end
    if (BITSLIP_LOW_CYCLES < 0) begin : g_bad_low
        $fatal(1, "taxi_eth_phy_10g_rx_block_lock: BITSLIP_LOW_CYCLES must be >= 0");
    end

    // One down-counter serves both slip phases; it is loaded with (cycles - 1).
    localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                             BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] TMR_HIGH = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOW  = TMR_W'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       sh_cnt_q, sh_cnt_d;
    logic [4:0]       sh_invld_cnt_q, sh_invld_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             bitslip_q, bitslip_d;
    logic             lock_q, lock_d;
    logic             loss_q, loss_d;
    logic [7:0]       slip_cnt_q, slip_cnt_d;

    logic             hdr_bad;
    logic [6:0]       sh_cnt_inc;
    logic [4:0]       sh_invld_inc;
    logic             start_slip;

    assign hdr_bad      = (serdes_rx_hdr == '0) || (serdes_rx_hdr == '1);
    assign sh_cnt_inc   = sh_cnt_q + 7'd1;
    assign sh_invld_inc = sh_invld_cnt_q + 5'(hdr_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_UNLOCKED;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            tmr_q          <= '0;
            bitslip_q      <= 1'b0;
            lock_q         <= 1'b0;
            loss_q         <= 1'b0;
            slip_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            sh_cnt_q       <= sh_cnt_d;
            sh_invld_cnt_q <= sh_invld_cnt_d;
            tmr_q          <= tmr_d;
            bitslip_q      <= bitslip_d;
            lock_q         <= lock_d;
            loss_q         <= loss_d;
            slip_cnt_q     <= slip_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sh_cnt_d       = sh_cnt_q;
        sh_invld_cnt_d = sh_invld_cnt_q;
        tmr_d          = tmr_q;
        bitslip_d      = bitslip_q;
        lock_d         = lock_q;
        loss_d         = 1'b0;
        slip_cnt_d     = slip_cnt_q;
        start_slip     = 1'b0;

        if (serdes_rx_reset_req) begin
            // Forced relock overrides whatever header arrives this cycle.
            state_d        = ST_UNLOCKED;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
            tmr_d          = '0;
            bitslip_d      = 1'b0;
            lock_d         = 1'b0;
            loss_d         = lock_q;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (serdes_rx_hdr_valid) begin
                        if (hdr_bad) begin
                            start_slip = 1'b1;
                        end else if (sh_cnt_inc == 7'd64) begin
                            state_d        = ST_LOCKED;
                            lock_d         = 1'b1;
                            sh_cnt_d       = '0;
                            sh_invld_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_cnt_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (serdes_rx_hdr_valid) begin
                        if (sh_invld_inc == 5'd16) begin
                            lock_d     = 1'b0;
                            loss_d     = 1'b1;
                            start_slip = 1'b1;
                        end else if (sh_cnt_inc == 7'd64) begin
                            sh_cnt_d       = '0;
                            sh_invld_cnt_d = '0;
                        end else begin
                            sh_cnt_d       = sh_cnt_inc;
                            sh_invld_cnt_d = sh_invld_inc;
                        end
                    end
                end
                ST_SLIP: begin
                    if (tmr_q == '0) begin
                        bitslip_d = 1'b0;
                        if (BITSLIP_LOW_CYCLES == 0) begin
                            state_d = ST_UNLOCKED;
                        end else begin
                            state_d = ST_SLIP_WAIT;
                            tmr_d   = TMR_LOW;
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_SLIP_WAIT: begin
                    if (tmr_q == '0) begin
                        state_d        = ST_UNLOCKED;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase

            if (start_slip) begin
                state_d        = ST_SLIP;
                bitslip_d      = 1'b1;
                tmr_d          = TMR_HIGH;
                sh_cnt_d       = '0;
                sh_invld_cnt_d = '0;
                if (slip_cnt_q != 8'hFF) begin
                    slip_cnt_d = slip_cnt_q + 8'd1;
                end
            end
        end
    end

    assign serdes_rx_bitslip = bitslip_q;
    assign rx_block_lock     = lock_q;
    assign rx_lock_loss      = loss_q;
    assign rx_slip_count     = slip_cnt_q;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_block_lock.sv
// Directed bench for the block-lock FSM; a behavioural model feeds a scoreboard
// queue each cycle, and key milestones are also checked against fixed values.
module tb_taxi_eth_phy_10g_rx_block_lock;

    localparam int HIGH = 1;
    localparam int LOW  = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] serdes_rx_hdr;
    logic       serdes_rx_hdr_valid;
    logic       serdes_rx_reset_req;
    logic       serdes_rx_bitslip;
    logic       rx_block_lock;
    logic       rx_lock_loss;
    logic [7:0] rx_slip_count;

    taxi_eth_phy_10g_rx_block_lock #(
        .HDR_W               (2),
        .BITSLIP_HIGH_CYCLES (HIGH),
        .BITSLIP_LOW_CYCLES  (LOW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .rx_block_lock       (rx_block_lock),
        .rx_lock_loss        (rx_lock_loss),
        .rx_slip_count       (rx_slip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       lock;
        logic       bs;
        logic       loss;
        logic [7:0] slips;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: lock flag, header counters, and remaining slip-phase cycles
    // (bitslip is expected high while more than LOW cycles remain).
    int   m_lock, m_loss, m_cnt, m_inv, m_rem, m_slips;

    task automatic model_reset();
        m_lock = 0; m_loss = 0; m_cnt = 0; m_inv = 0; m_rem = 0; m_slips = 0;
    endtask

    task automatic model_slip();
        m_rem = HIGH + LOW;
        m_cnt = 0;
        m_inv = 0;
        if (m_slips < 255) m_slips++;
    endtask

    task automatic model_step(input logic [1:0] hdr, input logic v, input logic req);
        bit bad;
        bad    = (hdr == 2'b00) || (hdr == 2'b11);
        m_loss = 0;
        if (req) begin
            m_loss = m_lock;
            m_lock = 0; m_rem = 0; m_cnt = 0; m_inv = 0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (v) begin
            m_cnt++;
            if (m_lock != 0) begin
                if (bad) m_inv++;
                if (m_inv == 16) begin
                    m_lock = 0;
                    m_loss = 1;
                    model_slip();
                end else if (m_cnt == 64) begin
                    m_cnt = 0;
                    m_inv = 0;
                end
            end else begin
                if (bad) model_slip();
                else if (m_cnt == 64) begin
                    m_lock = 1;
                    m_cnt  = 0;
                    m_inv  = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] hdr, input logic v, input logic req);
        exp_t e;
        serdes_rx_hdr       = hdr;
        serdes_rx_hdr_valid = v;
        serdes_rx_reset_req = req;
        model_step(hdr, v, req);
        e.lock  = (m_lock != 0);
        e.bs    = (m_rem > LOW);
        e.loss  = (m_loss != 0);
        e.slips = 8'(m_slips);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_lock",  8'(rx_block_lock),     8'(e.lock));
        chk("sb_bslip", 8'(serdes_rx_bitslip), 8'(e.bs));
        chk("sb_loss",  8'(rx_lock_loss),      8'(e.loss));
        chk("sb_slips", rx_slip_count,         e.slips);
    endtask

    function automatic logic [1:0] good_hdr(input int i);
        return (i % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        rst_n               = 1'b0;
        serdes_rx_hdr       = 2'b00;
        serdes_rx_hdr_valid = 1'b0;
        serdes_rx_reset_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lock",  8'(rx_block_lock),     8'd0);
        chk("rst_bslip", 8'(serdes_rx_bitslip), 8'd0);
        chk("rst_loss",  8'(rx_lock_loss),      8'd0);
        chk("rst_slips", rx_slip_count,         8'd0);
        rst_n = 1'b1;

        // Acquire lock with 64 good headers, a few valid gaps mixed in.
        for (int i = 0; i < 64; i++) begin
            if (i == 20) repeat (3) step(2'b00, 1'b0, 1'b0);
            if (i == 63) chk("pre_lock", 8'(rx_block_lock), 8'd0);
            step(good_hdr(i), 1'b1, 1'b0);
        end
        chk("lock_after_64", 8'(rx_block_lock), 8'd1);

        // 15 bad headers spread over one window: lock holds.
        for (int i = 0; i < 64; i++)
            step((i < 60 && i % 4 == 0) ? 2'b00 : good_hdr(i), 1'b1, 1'b0);
        chk("lock_15_bad", 8'(rx_block_lock), 8'd1);

        // 16 bad headers at the start of the next window: lock lost.
        for (int i = 0; i < 16; i++) step(2'b11, 1'b1, 1'b0);
        chk("loss_lock",  8'(rx_block_lock),     8'd0);
        chk("loss_pulse", 8'(rx_lock_loss),      8'd1);
        chk("loss_bslip", 8'(serdes_rx_bitslip), 8'd1);
        chk("loss_slips", rx_slip_count,         8'd1);
        for (int i = 0; i < HIGH + LOW; i++) step(2'b00, 1'b1, 1'b0);
        chk("ignored_slips", rx_slip_count, 8'd1);

        // Unlocked bad header: single slip, following bad headers ignored.
        step(2'b11, 1'b1, 1'b0);
        chk("slip_bslip", 8'(serdes_rx_bitslip), 8'd1);
        chk("slip_count", rx_slip_count,         8'd2);
        step(2'b11, 1'b1, 1'b0);
        chk("slip_bslip_off", 8'(serdes_rx_bitslip), 8'd0);
        for (int i = 1; i < HIGH + LOW; i++) step(2'b11, 1'b1, 1'b0);
        chk("slip_no_second", rx_slip_count, 8'd2);

        // Relock, then 16th bad header lands on the 64th header of the window.
        for (int i = 0; i < 64; i++) step(good_hdr(i), 1'b1, 1'b0);
        chk("relock", 8'(rx_block_lock), 8'd1);
        for (int i = 0; i < 48; i++) step(good_hdr(i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(2'b00, 1'b1, 1'b0);
        chk("coincide_lock",  8'(rx_block_lock),     8'd0);
        chk("coincide_loss",  8'(rx_lock_loss),      8'd1);
        chk("coincide_bslip", 8'(serdes_rx_bitslip), 8'd1);
        chk("coincide_slips", rx_slip_count,         8'd3);
        for (int i = 0; i < HIGH + LOW; i++) step(2'b01, 1'b1, 1'b0);

        // Forced relock request alongside a bad header while locked.
        for (int i = 0; i < 64; i++) step(good_hdr(i), 1'b1, 1'b0);
        chk("relock2", 8'(rx_block_lock), 8'd1);
        step(2'b11, 1'b1, 1'b1);
        chk("req_lock",  8'(rx_block_lock),     8'd0);
        chk("req_loss",  8'(rx_lock_loss),      8'd1);
        chk("req_bslip", 8'(serdes_rx_bitslip), 8'd0);
        chk("req_slips", rx_slip_count,         8'd3);
        step(2'b01, 1'b1, 1'b0);
        chk("req_loss_once", 8'(rx_lock_loss), 8'd0);

        // Continuous bad headers: slip counter saturates.
        for (int i = 0; i < 300 * (HIGH + LOW + 1); i++) step(2'b00, 1'b1, 1'b0);
        chk("slips_saturated", rx_slip_count, 8'd255);

        // Async reset in the middle of a slip pulse.
        for (int i = 0; i < 20 && serdes_rx_bitslip !== 1'b1; i++) step(2'b00, 1'b1, 1'b0);
        chk("in_slip", 8'(serdes_rx_bitslip), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bslip", 8'(serdes_rx_bitslip), 8'd0);
        chk("async_lock",  8'(rx_block_lock),     8'd0);
        chk("async_slips", rx_slip_count,         8'd0);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(good_hdr(i), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
